vga_fb_write_arbiter: RTL and testbench

Shares the single 1-bit write port of `framebuffer_bram` among up to `NREQ` pixel writers (character renderer, background fill, future scroll/sprite engines) in the `pixel_clk` domain of the VGA peripheral. It uses round-robin arbitration with a per-grant burst limit, so a 307,200-pixel background fill cannot starve character writes. The framebuffer write port is driven from registered outputs.

---
 rtl/vga_fb_write_arbiter_if.sv | 27 ++
 rtl/vga_fb_write_arbiter.sv | 150 +++++++++++++++
 tb/tb_vga_fb_write_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_write_arbiter_if.sv
// Framebuffer write-port bus shared by the pixel writers and the arbiter.
// The requester side drives req/addr/data/video_on. The arbiter drives the grant and
// the registered BRAM write port.
interface vga_fb_write_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 19
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ-1:0]    data_i;
  logic               video_on;
  logic [NREQ-1:0]    gnt_o;
  logic               fb_we;
  logic [AW-1:0]      fb_waddr;
  logic               fb_wdata;
  logic               busy_o;

  modport master (
    output req_i, addr_i, data_i, video_on,
    input  gnt_o, fb_we, fb_waddr, fb_wdata, busy_o
  );

  modport slave (
    input  req_i, addr_i, data_i, video_on,
    output gnt_o, fb_we, fb_waddr, fb_wdata, busy_o
  );
endinterface

// File: rtl/vga_fb_write_arbiter.sv
// Round-robin arbiter for the 1-bit framebuffer BRAM write port. It limits each grant
// to MAX_BURST accepted writes while another writer is waiting.
// Optional macro VGA_FB_ARB_BLANK_ONLY_EN: accept writes only while video_on is low.
module vga_fb_write_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned AW        = 19,
  parameter int unsigned MAX_BURST = 16
) (
  input logic                  pixel_clk,
  input logic                  wb_rst_i,
  vga_fb_write_arbiter_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {ArbIdle, ArbOwn} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            fb_we_q, fb_we_d;
  logic [AW-1:0]   fb_waddr_q, fb_waddr_d;
  logic            fb_wdata_q, fb_wdata_d;

  logic [NREQ-1:0] accept;
  logic            any_accept;
  logic [NREQ-1:0] others;
  logic [IW-1:0]   winner_all;
  logic [IW-1:0]   winner_oth;

  // First set bit strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last) + i) % NREQ;
      if (!found && req[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef VGA_FB_ARB_BLANK_ONLY_EN
  assign accept = bus.req_i & gnt_q & {NREQ{~bus.video_on}};
`else
  assign accept = bus.req_i & gnt_q;
  logic unused_video_on;
  assign unused_video_on = bus.video_on;
`endif

  assign any_accept = |accept;
  // The owner is excluded from the handover search.
  assign others     = bus.req_i & ~(NREQ'(1) << owner_q);
  assign winner_all = rr_pick(bus.req_i, last_owner_q);
  assign winner_oth = rr_pick(others, owner_q);

  // Next-state: grant selection, burst accounting and write-port capture.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    fb_we_d      = any_accept;
    fb_waddr_d   = fb_waddr_q;
    fb_wdata_d   = fb_wdata_q;

    if (any_accept) begin
      fb_waddr_d = bus.addr_i[32'(owner_q)*AW +: AW];
      fb_wdata_d = bus.data_i[owner_q];
    end

    unique case (state_q)
      ArbIdle: begin
        if (|bus.req_i) begin
          state_d     = ArbOwn;
          owner_d     = winner_all;
          gnt_d       = NREQ'(1) << winner_all;
          burst_cnt_d = '0;
        end
      end
      ArbOwn: begin
        if (!bus.req_i[owner_q]) begin
          last_owner_d = owner_q;
          burst_cnt_d  = '0;
          if (|others) begin
            owner_d = winner_oth;
            gnt_d   = NREQ'(1) << winner_oth;
          end else begin
            state_d = ArbIdle;
            gnt_d   = '0;
          end
        end else if (any_accept) begin
          // This write completes the burst. Hand over only if someone else is waiting.
          if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
            burst_cnt_d = '0;
            if (|others) begin
              last_owner_d = owner_q;
              owner_d      = winner_oth;
              gnt_d        = NREQ'(1) << winner_oth;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ArbIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered write port; reset drops any write accepted this cycle.
  always_ff @(posedge pixel_clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ArbIdle;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(NREQ - 1);
      burst_cnt_q  <= '0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= '0;
      fb_wdata_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      fb_we_q      <= fb_we_d;
      fb_waddr_q   <= fb_waddr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

  assign bus.gnt_o    = gnt_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_waddr = fb_waddr_q;
  assign bus.fb_wdata = fb_wdata_q;
  assign bus.busy_o   = (state_q == ArbOwn);
endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Directed bench for vga_fb_write_arbiter.
// Each requester k writes address (k<<16)+n with data n[0], where n is its own pixel count.
// The count advances only when a write is accepted.
module tb_vga_fb_write_arbiter;
  localparam int unsigned NREQ      = 3;
  localparam int unsigned AW        = 19;
  localparam int unsigned MAX_BURST = 16;

  logic pixel_clk = 1'b0;
  logic wb_rst_i;
  always #5 pixel_clk = ~pixel_clk;

  vga_fb_write_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  vga_fb_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .MAX_BURST(MAX_BURST)
  ) dut (
    .pixel_clk(pixel_clk),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  int              errors = 0;
  int              checks = 0;
  logic [NREQ-1:0] req;
  logic            vid;
  int unsigned     pix [NREQ];
  int unsigned     wr  [NREQ];
  logic [NREQ-1:0] prev_gnt;
  int              n;
  int              handovers;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      bus.addr_i[k*AW +: AW] = AW'((k << 16) | pix[k]);
      bus.data_i[k]          = pix[k][0];
    end
    bus.req_i    = req;
    bus.video_on = vid;
  endtask

  task automatic set_req(input logic [NREQ-1:0] r);
    req = r;
    drive();
  endtask

  task automatic clear_wr();
    for (int k = 0; k < NREQ; k++) wr[k] = 0;
  endtask

  // One clock. Check the write landed for whatever was accepted at this edge.
  task automatic tick();
    logic [NREQ-1:0] acc;
    logic [AW-1:0]   ea;
    logic            ed;
    acc = req & bus.gnt_o;
`ifdef VGA_FB_ARB_BLANK_ONLY_EN
    if (vid) acc = '0;
`endif
    ea = '0;
    ed = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k]) begin
        ea = AW'((k << 16) | pix[k]);
        ed = pix[k][0];
      end
    end
    @(posedge pixel_clk);
    #1;
    chk("fb_we", 32'(bus.fb_we), 32'(|acc));
    if (|acc) begin
      chk("fb_waddr", 32'(bus.fb_waddr), 32'(ea));
      chk("fb_wdata", 32'(bus.fb_wdata), 32'(ed));
    end
    chk("gnt_onehot0", 32'($onehot0(bus.gnt_o)), 32'd1);
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k]) begin
        pix[k]++;
        wr[k]++;
      end
    end
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1;
    req      = '0;
    vid      = 1'b0;
    for (int k = 0; k < NREQ; k++) pix[k] = 0;
    clear_wr();
    drive();
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_we", 32'(bus.fb_we), 32'd0);
    chk("rst_waddr", 32'(bus.fb_waddr), 32'd0);
    chk("rst_wdata", 32'(bus.fb_wdata), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    wb_rst_i = 1'b0;

    // Single requester: 20 writes, addr 0..19, one per cycle.
    set_req(3'b001);
    tick();
    chk("p1_gnt", 32'(bus.gnt_o), 32'(3'b001));
    chk("p1_busy", 32'(bus.busy_o), 32'd1);
    n = 0;
    while (wr[0] < 20 && n < 40) begin
      tick();
      n++;
    end
    chk("p1_throughput", 32'(n), 32'd20);
    chk("p1_last_addr", 32'(bus.fb_waddr), 32'd19);
    set_req(3'b000);
    tick();
    chk("p1_gnt_off", 32'(bus.gnt_o), 32'd0);
    chk("p1_busy_off", 32'(bus.busy_o), 32'd0);

    // Burst limit: last owner was 0, so requester 1 wins first; swap every 16 writes.
    clear_wr();
    set_req(3'b011);
    tick();
    chk("p2_gnt_first", 32'(bus.gnt_o), 32'(3'b010));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("p2_gnt_a", 32'(bus.gnt_o), (i < 15) ? 32'(3'b010) : 32'(3'b001));
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("p2_gnt_b", 32'(bus.gnt_o), (i < 15) ? 32'(3'b001) : 32'(3'b010));
    end
    chk("p2_wr0", wr[0], 32'd16);
    chk("p2_wr1", wr[1], 32'd16);
    chk("p2_busy", 32'(bus.busy_o), 32'd1);
    set_req(3'b000);
    tick();
    chk("p2_gnt_off", 32'(bus.gnt_o), 32'd0);

    // Fairness: last owner 1, so the order is 2,0,1,... and 199 writes in 200 cycles.
    clear_wr();
    set_req(3'b111);
    tick();
    chk("p3_gnt_first", 32'(bus.gnt_o), 32'(3'b100));
    prev_gnt  = bus.gnt_o;
    handovers = 0;
    for (int i = 0; i < 199; i++) begin
      tick();
      if (bus.gnt_o != prev_gnt) begin
        chk("p3_order", 32'(bus.gnt_o), 32'({prev_gnt[1:0], prev_gnt[2]}));
        handovers++;
        prev_gnt = bus.gnt_o;
      end
    end
    chk("p3_handovers", 32'(handovers), 32'd12);
    chk("p3_wr0", wr[0], 32'd64);
    chk("p3_wr1", wr[1], 32'd64);
    chk("p3_wr2", wr[2], 32'd71);
    set_req(3'b000);
    tick();
    chk("p3_gnt_off", 32'(bus.gnt_o), 32'd0);

    // Early release: requester 2 drops after 5 writes while requester 0 waits.
    clear_wr();
    set_req(3'b100);
    tick();
    chk("p4_gnt2", 32'(bus.gnt_o), 32'(3'b100));
    set_req(3'b101);
    n = 0;
    while (wr[2] < 5 && n < 20) begin
      tick();
      n++;
    end
    chk("p4_cycles", 32'(n), 32'd5);
    set_req(3'b001);
    tick();
    chk("p4_gnt0", 32'(bus.gnt_o), 32'(3'b001));
    chk("p4_wr2", wr[2], 32'd5);
    chk("p4_wr0_none", wr[0], 32'd0);
    tick();
    tick();
    chk("p4_wr0", wr[0], 32'd2);
    set_req(3'b000);
    tick();
    chk("p4_gnt_off", 32'(bus.gnt_o), 32'd0);

    // Reset during a requester-1 burst. Afterwards requester 0 wins from the reset pointer.
    set_req(3'b010);
    tick();
    chk("p5_gnt1", 32'(bus.gnt_o), 32'(3'b010));
    repeat (3) tick();
    set_req(3'b011);
    wb_rst_i = 1'b1;
    #1;
    chk("p5_rst_we", 32'(bus.fb_we), 32'd0);
    chk("p5_rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("p5_rst_busy", 32'(bus.busy_o), 32'd0);
    @(posedge pixel_clk);
    #1;
    chk("p5_rst_hold_we", 32'(bus.fb_we), 32'd0);
    wb_rst_i = 1'b0;
    tick();
    chk("p5_gnt0", 32'(bus.gnt_o), 32'(3'b001));
    tick();
    set_req(3'b000);
    tick();
    tick();
    chk("p5_gnt_off", 32'(bus.gnt_o), 32'd0);

    // video_on high for 10 cycles, then low.
    clear_wr();
    vid = 1'b1;
    set_req(3'b001);
    for (int i = 0; i < 10; i++) tick();
    chk("p6_gnt", 32'(bus.gnt_o), 32'(3'b001));
`ifdef VGA_FB_ARB_BLANK_ONLY_EN
    chk("p6_wr_active", wr[0], 32'd0);
`else
    chk("p6_wr_active", wr[0], 32'd9);
`endif
    vid = 1'b0;
    drive();
    tick();
    chk("p6_we_blank", 32'(bus.fb_we), 32'd1);
`ifdef VGA_FB_ARB_BLANK_ONLY_EN
    chk("p6_wr_blank", wr[0], 32'd1);
`else
    chk("p6_wr_blank", wr[0], 32'd10);
`endif
    set_req(3'b000);
    tick();
    chk("p6_gnt_off", 32'(bus.gnt_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
